// File: rtl/vga_pan_if.sv
// vga_pan_if
// Bundles the pan controller's control inputs and offset outputs.
//   button[6:3]   raw direction buttons (3=up, 4=right, 5=down, 6=left)
//   frame_start   one-cycle pulse at the start of vertical blanking
//   home          level request to recentre the picture
//   h_shift       horizontal pan offset, 10 bits
//   v_shift       vertical pan offset, 10 bits
//   shift_update  one-cycle pulse whenever an offset is rewritten
//   moving        high while the sequencer is not idle
// The master modport drives the inputs; the slave modport is the controller.
interface vga_pan_if;
    logic [6:3] button;
    logic       frame_start;
    logic       home;
    logic [9:0] h_shift;
    logic [9:0] v_shift;
    logic       shift_update;
    logic       moving;

    modport master (
        output button, frame_start, home,
        input  h_shift, v_shift, shift_update, moving
    );

    modport slave (
        input  button, frame_start, home,
        output h_shift, v_shift, shift_update, moving
    );
endinterface

// File: rtl/vga_pan_ctrl.sv
// vga_pan_ctrl
// Frame-aligned pan/scroll sequencer for the VGA pattern generator.
// The four direction buttons are synchronised and debounced. A
// press / delay / repeat / fast state machine then steps the h_shift and
// v_shift offsets, always on the edge that follows a frame_start pulse,
// so that the picture never moves in the middle of a frame.
// Ports:
//   pixel_clk  single clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        vga_pan_if.slave (button, frame_start, home in;
//              h_shift, v_shift, shift_update, moving out)
module vga_pan_ctrl #(
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int REPEAT_DELAY    = 30,
    parameter int REPEAT_RATE     = 4,
    parameter int ACCEL_STEPS     = 16,
    parameter int STEP_SLOW       = 1,
    parameter int STEP_FAST       = 4
) (
    input  logic     pixel_clk,
    input  logic     rst_n,
    vga_pan_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FIRST  = 3'd1,
        ST_DELAY  = 3'd2,
        ST_REPEAT = 3'd3,
        ST_FAST   = 3'd4
    } state_t;

    localparam int DBW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int FMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int FCW  = $clog2(FMAX + 1);
    localparam int SCW  = $clog2(ACCEL_STEPS + 1);

    localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [FCW-1:0] RD_LAST  = FCW'(REPEAT_DELAY - 1);
    localparam logic [FCW-1:0] RR_LAST  = FCW'(REPEAT_RATE - 1);
    localparam logic [SCW-1:0] ACC_LAST = SCW'(ACCEL_STEPS - 1);
    localparam logic [9:0]     SLOW_INC = 10'(STEP_SLOW);
    localparam logic [9:0]     FAST_INC = 10'(STEP_FAST);

    // Move one axis by amt in the pressed direction; arithmetic wraps mod 1024.
    function automatic logic [9:0] apply_step(input logic [9:0] base,
                                              input logic       inc,
                                              input logic       dec,
                                              input logic [9:0] amt);
        logic [9:0] res;
        if (inc) begin
            res = base + amt;
        end else if (dec) begin
            res = base - amt;
        end else begin
            res = base;
        end
        return res;
    endfunction

    logic [6:3]     sync1_r;
    logic [6:3]     sync2_r;
    logic [6:3]     db_r;
    logic [DBW-1:0] db_cnt_r [6:3];

    // Direction vector {x_inc, x_dec, y_inc, y_dec}; opposite buttons cancel.
    logic [3:0]     vec_s;
    logic [3:0]     dir_r;
    logic [3:0]     dir_nxt_s;

    state_t         state_r;
    state_t         state_nxt_s;
    logic [FCW-1:0] frame_cnt_r;
    logic [FCW-1:0] frame_cnt_nxt_s;
    logic [SCW-1:0] step_cnt_r;
    logic [SCW-1:0] step_cnt_nxt_s;
    logic           step_s;
    logic           step_fast_s;

    logic [9:0]     h_shift_r;
    logic [9:0]     v_shift_r;
    logic           shift_update_r;
    logic           moving_r;
    logic [9:0]     h_nxt_s;
    logic [9:0]     v_nxt_s;
    logic           upd_nxt_s;
    logic [9:0]     step_amt_s;

    // Two-flop synchroniser for the raw asynchronous buttons.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 4'b0000;
            sync2_r <= 4'b0000;
        end else begin
            sync1_r <= bus.button;
            sync2_r <= sync1_r;
        end
    end

    // Per-button debounce: flip only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            db_r <= 4'b0000;
            for (int i = 3; i <= 6; i++) begin
                db_cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 3; i <= 6; i++) begin
                if (sync2_r[i] == db_r[i]) begin
                    db_cnt_r[i] <= '0;
                end else if (db_cnt_r[i] == DB_LAST) begin
                    db_r[i]     <= sync2_r[i];
                    db_cnt_r[i] <= '0;
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + DBW'(1);
                end
            end
        end
    end

    // Decode debounced buttons: right=4, left=6, down=5, up=3.
    always_comb begin
        vec_s = {db_r[4] & ~db_r[6], db_r[6] & ~db_r[4],
                 db_r[5] & ~db_r[3], db_r[3] & ~db_r[5]};
    end

    // Sequencer state, frame/step counters and latched press direction.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            frame_cnt_r <= '0;
            step_cnt_r  <= '0;
            dir_r       <= 4'b0000;
        end else begin
            state_r     <= state_nxt_s;
            frame_cnt_r <= frame_cnt_nxt_s;
            step_cnt_r  <= step_cnt_nxt_s;
            dir_r       <= dir_nxt_s;
        end
    end

    // Next state: home wins, release/change restart, otherwise frame-paced stepping.
    always_comb begin
        state_nxt_s     = state_r;
        frame_cnt_nxt_s = frame_cnt_r;
        step_cnt_nxt_s  = step_cnt_r;
        dir_nxt_s       = dir_r;
        step_s          = 1'b0;
        step_fast_s     = 1'b0;
        if (bus.home) begin
            state_nxt_s     = ST_IDLE;
            frame_cnt_nxt_s = '0;
            step_cnt_nxt_s  = '0;
            dir_nxt_s       = 4'b0000;
        end else if (state_r == ST_IDLE) begin
            if (vec_s != 4'b0000) begin
                // A frame_start in this same cycle deliberately does not step.
                state_nxt_s     = ST_FIRST;
                frame_cnt_nxt_s = '0;
                step_cnt_nxt_s  = '0;
                dir_nxt_s       = vec_s;
            end else begin
                state_nxt_s = ST_IDLE;
            end
        end else if (vec_s == 4'b0000) begin
            state_nxt_s     = ST_IDLE;
            frame_cnt_nxt_s = '0;
            step_cnt_nxt_s  = '0;
            dir_nxt_s       = 4'b0000;
        end else if (vec_s != dir_r) begin
            // New direction is handled as a fresh press.
            state_nxt_s     = ST_FIRST;
            frame_cnt_nxt_s = '0;
            step_cnt_nxt_s  = '0;
            dir_nxt_s       = vec_s;
        end else if (bus.frame_start) begin
            case (state_r)
                ST_FIRST: begin
                    step_s          = 1'b1;
                    state_nxt_s     = ST_DELAY;
                    frame_cnt_nxt_s = '0;
                end
                ST_DELAY: begin
                    if (frame_cnt_r == RD_LAST) begin
                        step_s          = 1'b1;
                        state_nxt_s     = ST_REPEAT;
                        frame_cnt_nxt_s = '0;
                        step_cnt_nxt_s  = '0;
                    end else begin
                        frame_cnt_nxt_s = frame_cnt_r + FCW'(1);
                    end
                end
                ST_REPEAT: begin
                    if (frame_cnt_r == RR_LAST) begin
                        step_s          = 1'b1;
                        frame_cnt_nxt_s = '0;
                        if (step_cnt_r == ACC_LAST) begin
                            state_nxt_s    = ST_FAST;
                            step_cnt_nxt_s = '0;
                        end else begin
                            step_cnt_nxt_s = step_cnt_r + SCW'(1);
                        end
                    end else begin
                        frame_cnt_nxt_s = frame_cnt_r + FCW'(1);
                    end
                end
                ST_FAST: begin
                    if (frame_cnt_r == RR_LAST) begin
                        step_s          = 1'b1;
                        step_fast_s     = 1'b1;
                        frame_cnt_nxt_s = '0;
                    end else begin
                        frame_cnt_nxt_s = frame_cnt_r + FCW'(1);
                    end
                end
                default: begin
                    state_nxt_s     = ST_IDLE;
                    frame_cnt_nxt_s = '0;
                    step_cnt_nxt_s  = '0;
                    dir_nxt_s       = 4'b0000;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Output decode: next offsets and update pulse from home / step decisions.
    always_comb begin
        h_nxt_s    = h_shift_r;
        v_nxt_s    = v_shift_r;
        upd_nxt_s  = 1'b0;
        step_amt_s = step_fast_s ? FAST_INC : SLOW_INC;
        if (bus.home) begin
            h_nxt_s   = 10'd0;
            v_nxt_s   = 10'd0;
            upd_nxt_s = 1'b1;
        end else if (step_s) begin
            h_nxt_s   = apply_step(h_shift_r, vec_s[3], vec_s[2], step_amt_s);
            v_nxt_s   = apply_step(v_shift_r, vec_s[1], vec_s[0], step_amt_s);
            upd_nxt_s = 1'b1;
        end else begin
            upd_nxt_s = 1'b0;
        end
    end

    // Registered outputs.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_shift_r      <= 10'd0;
            v_shift_r      <= 10'd0;
            shift_update_r <= 1'b0;
            moving_r       <= 1'b0;
        end else begin
            h_shift_r      <= h_nxt_s;
            v_shift_r      <= v_nxt_s;
            shift_update_r <= upd_nxt_s;
            moving_r       <= (state_nxt_s != ST_IDLE);
        end
    end

    assign bus.h_shift      = h_shift_r;
    assign bus.v_shift      = v_shift_r;
    assign bus.shift_update = shift_update_r;
    assign bus.moving       = moving_r;

endmodule
